// File: rtl/spi_rx_fifo.sv
// spi_rx_fifo: FWFT receive buffer behind the SPI master; counts accepted words, flags overflow.
// Latency: a word written at edge N is visible on o_data / o_count after edge N (next cycle).
// Backpressure: none toward the SPI master; words arriving while full are dropped, or with
// SPI_RX_OVERWRITE_EN defined they replace the oldest entry. Either way o_overflow is set.
module spi_rx_fifo #(
  parameter int SPI_DATA_WIDTH    = 32,
  parameter int FIFO_DEPTH_LOG2   = 4,
  parameter int ALMOST_FULL_LEVEL = 12,
  parameter int FRAME_COUNT_WIDTH = 16
) (
  input  logic                         i_clock,
  input  logic                         i_reset,
  input  logic                         i_spi_done,
  input  logic [SPI_DATA_WIDTH-1:0]    i_spi_data,
  input  logic                         i_read,
  input  logic                         i_flush,
  input  logic                         i_clear_overflow,
  output logic [SPI_DATA_WIDTH-1:0]    o_data,
  output logic                         o_empty,
  output logic                         o_full,
  output logic                         o_almost_full,
  output logic [FIFO_DEPTH_LOG2:0]     o_count,
  output logic                         o_overflow,
  output logic [FRAME_COUNT_WIDTH-1:0] o_frame_count
);

  localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
  localparam logic [FIFO_DEPTH_LOG2:0] DEPTH_CNT = (FIFO_DEPTH_LOG2+1)'(DEPTH);
  localparam logic [FIFO_DEPTH_LOG2:0] AF_CNT    = (FIFO_DEPTH_LOG2+1)'(ALMOST_FULL_LEVEL);

  logic [SPI_DATA_WIDTH-1:0]    mem_q [DEPTH];
  logic [FIFO_DEPTH_LOG2-1:0]   wr_ptr_q, wr_ptr_d;
  logic [FIFO_DEPTH_LOG2-1:0]   rd_ptr_q, rd_ptr_d;
  logic [FIFO_DEPTH_LOG2:0]     count_q, count_d;
  logic                         overflow_q, overflow_d;
  logic [FRAME_COUNT_WIDTH-1:0] frame_count_q, frame_count_d;

  logic full, empty;
  logic pop_ok;      // pop that actually dequeues
  logic wr_ok;       // write with a free slot (or one freed by a same-cycle pop)
  logic ovf_evt;     // write arriving while full with no pop
  logic ovw;         // overflow event that replaces the oldest entry
  logic mem_we;

  // Next-state bookkeeping for pointers, occupancy, sticky overflow and word counter
  always_comb begin
    full          = (count_q == DEPTH_CNT);
    empty         = (count_q == '0);
    pop_ok        = i_read && !empty;
    wr_ok         = i_spi_done && (!full || pop_ok);
    ovf_evt       = i_spi_done && full && !pop_ok;
`ifdef SPI_RX_OVERWRITE_EN
    ovw           = ovf_evt;
`else
    ovw           = 1'b0;
`endif
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    overflow_d    = overflow_q;
    frame_count_d = frame_count_q;
    mem_we        = 1'b0;

    if (i_flush) begin
      // Flush discards any same-cycle write or pop; overflow clear still honoured.
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      if (i_clear_overflow) overflow_d = 1'b0;
    end else begin
      mem_we = wr_ok || ovw;
      if (wr_ok || ovw) begin
        wr_ptr_d      = wr_ptr_q + 1'b1;
        frame_count_d = frame_count_q + 1'b1;
      end
      if (pop_ok || ovw) rd_ptr_d = rd_ptr_q + 1'b1;
      // In overwrite mode count stays at depth since the oldest slot is reused.
      if (wr_ok && !pop_ok)      count_d = count_q + 1'b1;
      else if (pop_ok && !wr_ok) count_d = count_q - 1'b1;
      // Set has priority over clear when both happen together.
      if (ovf_evt)               overflow_d = 1'b1;
      else if (i_clear_overflow) overflow_d = 1'b0;
    end
  end

  // Control state register; reset wins over every other input
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      overflow_q    <= 1'b0;
      frame_count_q <= '0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      overflow_q    <= overflow_d;
      frame_count_q <= frame_count_d;
    end
  end

  // Storage array; contents are left untouched by reset, only the write is suppressed
  always_ff @(posedge i_clock) begin
    if (!i_reset && mem_we) mem_q[wr_ptr_q] <= i_spi_data;
  end

  // First-word-fall-through head and flags derived from the registered count
  always_comb begin
    o_data        = mem_q[rd_ptr_q];
    o_empty       = empty;
    o_full        = full;
    o_almost_full = (count_q >= AF_CNT);
    o_count       = count_q;
    o_overflow    = overflow_q;
    o_frame_count = frame_count_q;
  end

endmodule

// File: doc/spi_rx_fifo.md
Name: spi_rx_fifo

Overview:
Receive-side buffer downstream of the SPI master core. Captures each completed SPI word (data-out plus one-cycle done pulse) into a first-word-fall-through FIFO. Exposes a pop interface and status flags to the consuming logic. Tracks overflow and a running count of accepted words.

Parameters:
SPI_DATA_WIDTH, 32, width of one SPI word, matching the SPI master data width.
FIFO_DEPTH_LOG2, 4, log2 of FIFO depth. Depth is 16 by default.
ALMOST_FULL_LEVEL, 12, occupancy at or above which o_almost_full asserts. Range 1..depth.
FRAME_COUNT_WIDTH, 16, width of the accepted-word counter.

Ports:
i_clock  input  1  system clock; all logic is on the rising edge.
i_reset  input  1  synchronous, active-high reset.
i_spi_done  input  1  one-cycle pulse from the SPI master when a word completes.
i_spi_data  input  SPI_DATA_WIDTH  received word. Valid in the cycle i_spi_done is high.
i_read  input  1  pop request. Acts only when o_empty=0.
i_flush  input  1  synchronous FIFO clear.
i_clear_overflow  input  1  clears the sticky overflow flag.
o_data  output  SPI_DATA_WIDTH  head-of-FIFO word (FWFT). Meaningful only when o_empty=0.
o_empty  output  1  FIFO holds no words.
o_full  output  1  FIFO holds 2^FIFO_DEPTH_LOG2 words.
o_almost_full  output  1  count >= ALMOST_FULL_LEVEL.
o_count  output  FIFO_DEPTH_LOG2+1  current occupancy, 0..depth.
o_overflow  output  1  sticky: a write arrived while full.
o_frame_count  output  FRAME_COUNT_WIDTH  number of words accepted since reset. Wraps modulo 2^FRAME_COUNT_WIDTH.

Behaviour:
- Reset (i_reset=1, sampled on clock edge):
  - Write/read pointers and count go to 0.
  - o_empty=1, o_full=0, o_almost_full=0, o_overflow=0, o_frame_count=0.
  - Memory contents are not cleared.
  - Reset overrides every other input, including mid-stream done pulses.
- Storage: register array of depth entries.
  - o_data = mem[rd_ptr], combinational from the array.
  - Pointers are FIFO_DEPTH_LOG2 bits and wrap naturally from depth-1 to 0.
- Write: i_spi_done=1 and not full, or full with a simultaneous valid pop.
  - mem[wr_ptr] <= i_spi_data, wr_ptr++, o_frame_count++.
  - Latency: a word written into an empty FIFO appears on o_data, and o_empty falls, on the next cycle.
- Pop: i_read=1 and o_empty=0. rd_ptr++. The next word appears on o_data the following cycle.
- i_read while empty is ignored: no state change, no error flag.
- Simultaneous write and pop:
  - Non-empty, non-full FIFO: both occur and count is unchanged.
  - Empty FIFO: only the write occurs; the pop is ignored.
  - Full FIFO: the pop frees a slot and the write is accepted; count stays at depth; no overflow.
- Write while full without a pop (base behaviour):
  - The word is dropped and o_frame_count is unchanged.
  - o_overflow <= 1, and stays 1 until cleared.
- i_clear_overflow=1 clears o_overflow. If an overflow event occurs in the same cycle, set wins and o_overflow stays 1.
- i_flush=1:
  - Pointers and count go to 0 next cycle.
  - Any same-cycle write or pop is discarded.
  - o_overflow and o_frame_count are unaffected.
- Flags are registered or derived from the registered count and update in the same cycle as o_count:
  - o_empty = (count==0)
  - o_full = (count==depth)
  - o_almost_full = (count>=ALMOST_FULL_LEVEL)
- No state machine beyond pointer/count bookkeeping. The block applies no back-pressure to the SPI master; dropped words are signalled only via o_overflow.

Optional Feature:
Macro SPI_RX_OVERWRITE_EN.
- Defined: a write while full with no pop discards the oldest entry and stores the new word.
  - rd_ptr++ and wr_ptr++; count stays at depth.
  - o_overflow <= 1 and o_frame_count++.
  - o_data shows the second-oldest word next cycle.
- Undefined: the new word is dropped, as in Behaviour.

Test Plan:
- Reset, then one done pulse with data 0xA5A5_0001 -> next cycle o_empty=0, o_data=0xA5A5_0001, o_count=1, o_frame_count=1. Pop -> o_empty=1, o_count=0.
- Write 12 words 0x100..0x10B -> o_almost_full rises on the cycle after the 12th write. Pop all 12 -> data emerges in order 0x100..0x10B, then o_empty=1.
- Write 17 words 0x200..0x210 with no pops, base build -> o_full=1, o_count=16, o_overflow=1, o_frame_count=16. Head remains 0x200. Pop 16 -> last word is 0x20F.
- Same stimulus, SPI_RX_OVERWRITE_EN build -> o_frame_count=17, head=0x201, last popped word=0x210.
- Full FIFO with done and i_read in the same cycle -> o_count stays 16, o_overflow stays 0, new word is last out. Assert i_clear_overflow and an overflow event together -> o_overflow=1.
- Write 5 words, then i_flush together with a done pulse -> next cycle o_count=0, o_empty=1, o_frame_count=5. Write 20 more and pop all -> pointers wrap with no data corruption.
